// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus for the boot loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_byte, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream, writes them
// to instruction memory and releases the core once the XOR checksum matches.
module prog_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

  typedef enum logic [2:0] {
    CNT_HI, CNT_LO, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [7:0]         acc_q, acc_d;
  logic [31:0]        word_q, word_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               in_ready_c;
  logic               accept_c;
  logic [CNT_W-1:0]   n_c;
  logic [CNT_W-1:0]   idx_inc_c;
  logic [31:0]        word_next_c;

  // Ready decodes state only; gated by reset so nothing is taken while held
  always_comb begin
    in_ready_c = 1'b0;
    case (state_q)
      CNT_HI, CNT_LO, DATA, CHK: in_ready_c = 1'b1;
      default:                   in_ready_c = 1'b0;
    endcase
    in_ready_c = in_ready_c & reset;
  end

  assign accept_c    = bus.in_valid & in_ready_c;
  assign n_c         = {cnt_q[15:8], bus.in_byte};
  assign idx_inc_c   = idx_q + CNT_W'(1);
  assign word_next_c = {word_q[23:0], bus.in_byte};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CNT_HI;
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output decode; write strobe is a one-cycle pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      CNT_HI: begin
        if (accept_c) begin
          cnt_d   = {bus.in_byte, 8'h00};
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept_c) begin
          cnt_d = n_c;
          if (n_c == '0 || n_c > MAX_N) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            idx_d   = '0;
            bcnt_d  = '0;
            acc_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept_c) begin
          word_d = word_next_c;
          acc_d  = acc_q ^ bus.in_byte;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'({idx_q, 2'b00});
            wdata_d = word_next_c;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        idx_d   = idx_inc_c;
        state_d = (idx_inc_c == cnt_q) ? CHK : DATA;
      end
      CHK: begin
        if (accept_c) begin
          if (bus.in_byte == acc_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign done           = done_q;
  assign error          = err_q;

endmodule
